alu_seq: RTL and testbench

Parametrised multi-function ALU for the CPU datapath, replacing the two-op add/sub unit. Supports arithmetic, logic, shift and an iterative shift-add multiply. Operands are captured on a start strobe, the result is registered, and a flag register (C, Z, N, V) is updated under a write enable. Sits between the A/B registers and the bus driver; the control sequencer reads the flags for conditional jumps.

---
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_seq.sv | 174 +++++++++++++++++
 tb/tb_alu_seq.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Operand/command and result/flag bundle between the datapath sequencer and alu_seq.
interface alu_seq_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  i_start;
    logic [3:0]            i_op;
    logic [DATA_WIDTH-1:0] i_a;
    logic [DATA_WIDTH-1:0] i_b;
    logic                  i_flag_we;
    logic [DATA_WIDTH-1:0] o_c;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_cf;
    logic                  o_zf;
    logic                  o_nf;
    logic                  o_vf;

    modport master (
        output i_start, i_op, i_a, i_b, i_flag_we,
        input  o_c, o_busy, o_done, o_cf, o_zf, o_nf, o_vf
    );

    modport slave (
        input  i_start, i_op, i_a, i_b, i_flag_we,
        output o_c, o_busy, o_done, o_cf, o_zf, o_nf, o_vf
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-function ALU: single-cycle arithmetic/logic/shift ops and an iterative
// shift-add multiply, with registered result and C/Z/N/V flag register.
module alu_seq #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input logic      i_clk,
    input logic      i_rst,
    alu_seq_if.slave bus
);
    localparam int unsigned W    = DATA_WIDTH;
    localparam int unsigned CntW = $clog2(W) + 1;

    typedef enum logic {StIdle, StMul} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    c_q, c_d;
    logic            cf_q, cf_d, zf_q, zf_d, nf_q, nf_d, vf_q, vf_d;
    logic            busy_q, busy_d, done_q, done_d, we_q, we_d;
    logic [2*W-1:0]  mcand_q, mcand_d, acc_q, acc_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Single-cycle datapath
    logic [W-1:0] opb, res;
    logic [W:0]   sum;
    logic         cin, is_sub, is_arith, alu_c, alu_v;

    always_comb begin
        opb      = bus.i_b;
        cin      = 1'b0;
        is_sub   = 1'b0;
        is_arith = 1'b1;
        case (bus.i_op)
            4'd1:    is_sub = 1'b1;
            4'd2:    cin = cf_q;
            4'd3:    begin is_sub = 1'b1; cin = cf_q; end
            4'd10:   opb = W'(1);
            4'd11:   begin opb = W'(1); is_sub = 1'b1; end
            4'd0:    ;
            default: is_arith = 1'b0;
        endcase

        // Bit W of the wide difference is the borrow out.
        if (is_sub) begin
            sum = {1'b0, bus.i_a} - {1'b0, opb} - {{W{1'b0}}, cin};
        end else begin
            sum = {1'b0, bus.i_a} + {1'b0, opb} + {{W{1'b0}}, cin};
        end

        res   = sum[W-1:0];
        alu_c = 1'b0;
        alu_v = 1'b0;
        if (is_arith) begin
            alu_c = sum[W];
            alu_v = ((bus.i_a[W-1] ^ opb[W-1]) == is_sub) && (res[W-1] != bus.i_a[W-1]);
        end else begin
            case (bus.i_op)
                4'd4:    res = bus.i_a & bus.i_b;
                4'd5:    res = bus.i_a | bus.i_b;
                4'd6:    res = bus.i_a ^ bus.i_b;
                4'd7:    res = ~bus.i_a;
                4'd8:    begin res = {bus.i_a[W-2:0], 1'b0}; alu_c = bus.i_a[W-1]; end
                4'd9:    begin res = {1'b0, bus.i_a[W-1:1]}; alu_c = bus.i_a[0]; end
                default: res = bus.i_b;
            endcase
        end
    end

    // Multiply step
    logic [2*W-1:0] acc_step;
    logic           mul_hi;
    assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign mul_hi   = |acc_step[2*W-1:W];

    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        cf_d     = cf_q;
        zf_d     = zf_q;
        nf_d     = nf_q;
        vf_d     = vf_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        we_d     = we_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    if (bus.i_op == 4'd12) begin
                        mcand_d  = {{W{1'b0}}, bus.i_a};
                        mplier_d = bus.i_b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        we_d     = bus.i_flag_we;
                        busy_d   = 1'b1;
                        state_d  = StMul;
                    end else begin
                        c_d    = res;
                        done_d = 1'b1;
                        if (bus.i_flag_we) begin
                            cf_d = alu_c;
                            vf_d = alu_v;
                            zf_d = (res == '0);
                            nf_d = res[W-1];
                        end
                    end
                end
            end
            StMul: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CntW'(W - 1)) begin
                    c_d     = acc_step[W-1:0];
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                    if (we_q) begin
                        cf_d = mul_hi;
                        vf_d = mul_hi;
                        zf_d = (acc_step[W-1:0] == '0);
                        nf_d = acc_step[W-1];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= StIdle;
            c_q      <= '0;
            cf_q     <= 1'b0;
            zf_q     <= 1'b0;
            nf_q     <= 1'b0;
            vf_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            cf_q     <= cf_d;
            zf_q     <= zf_d;
            nf_q     <= nf_d;
            vf_q     <= vf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            we_q     <= we_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.o_c    = c_q;
    assign bus.o_cf   = cf_q;
    assign bus.o_zf   = zf_q;
    assign bus.o_nf   = nf_q;
    assign bus.o_vf   = vf_q;
    assign bus.o_busy = busy_q;
    assign bus.o_done = done_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed corner vectors then random ops,
// checked against an integer-arithmetic reference model.
module tb_alu_seq;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_if #(.DATA_WIDTH(W)) bus ();
    alu_seq #(.DATA_WIDTH(W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int unsigned sb[$];
    int vectors     = 0;
    int miscompares = 0;
    int m_cf = 0, m_zf = 0, m_nf = 0, m_vf = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sgn(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    // Reference model: compute result/flags from the operation rules, push expectation.
    task automatic model(input int op, input int a, input int b, input int we);
        int t, st, r, c, v;
        c = 0; v = 0; st = 0;
        case (op)
            0:  begin t = a + b;        st = sgn(a) + sgn(b);        c = int'(t > 255); end
            1:  begin t = a - b;        st = sgn(a) - sgn(b);        c = int'(t < 0);   end
            2:  begin t = a + b + m_cf; st = sgn(a) + sgn(b) + m_cf; c = int'(t > 255); end
            3:  begin t = a - b - m_cf; st = sgn(a) - sgn(b) - m_cf; c = int'(t < 0);   end
            4:  t = a & b;
            5:  t = a | b;
            6:  t = a ^ b;
            7:  t = ~a;
            8:  begin t = a * 2;  c = (a >> 7) & 1; end
            9:  begin t = a / 2;  c = a & 1;        end
            10: begin t = a + 1; st = sgn(a) + 1; c = int'(t > 255); end
            11: begin t = a - 1; st = sgn(a) - 1; c = int'(t < 0);   end
            12: begin t = a * b; c = int'((t / 256) != 0); v = c; end
            default: t = b;
        endcase
        r = t & 255;
        if (op <= 3 || op == 10 || op == 11) v = int'(st > 127 || st < -128);
        if (we != 0) begin
            m_cf = c;
            m_vf = v;
            m_zf = int'(r == 0);
            m_nf = (r >> 7) & 1;
        end
        sb.push_back(unsigned'((r << 4) | (m_cf << 3) | (m_zf << 2) | (m_nf << 1) | m_vf));
    endtask

    always @(negedge clk) begin
        if (!rst && bus.o_done) begin
            check("done_while_busy", int'(bus.o_busy), 0);
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                check("result_flags",
                      int'({bus.o_c, bus.o_cf, bus.o_zf, bus.o_nf, bus.o_vf}),
                      int'(sb.pop_front()));
            end
        end
    end

    // Called just after a negedge; returns at a negedge with start released.
    task automatic issue(input int op, input int a, input int b, input int we, input bit poke);
        int n;
        bus.i_start   = 1'b1;
        bus.i_op      = 4'(op);
        bus.i_a       = 8'(a);
        bus.i_b       = 8'(b);
        bus.i_flag_we = 1'(we);
        model(op, a, b, we);
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        if (op == 12) begin
            n = 0;
            forever begin
                @(negedge clk);
                if (!bus.o_busy || n > 40) break;
                n++;
                // A start mid-multiply with scrambled operands must be ignored.
                if (poke && n == 3) begin
                    bus.i_start = 1'b1;
                    bus.i_op    = 4'($urandom_range(0, 11));
                    bus.i_a     = 8'($urandom);
                    bus.i_b     = 8'($urandom);
                end else begin
                    bus.i_start = 1'b0;
                end
            end
            bus.i_start = 1'b0;
            check("mul_busy_cycles", n, W);
        end else begin
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion by 200000");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        bus.i_start   = 1'b0;
        bus.i_op      = '0;
        bus.i_a       = '0;
        bus.i_b       = '0;
        bus.i_flag_we = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state",
              int'({bus.o_c, bus.o_cf, bus.o_zf, bus.o_nf, bus.o_vf, bus.o_busy, bus.o_done}), 0);
        rst = 1'b0;
        @(negedge clk);

        issue(0,  'hFF, 'h01, 1, 0);
        issue(2,  'h10, 'h20, 1, 0);
        issue(1,  'h80, 'h01, 1, 0);
        issue(1,  'h01, 'h02, 1, 0);
        issue(8,  'h81, 'h00, 1, 0);
        issue(9,  'h01, 'h00, 1, 0);
        issue(4,  'hF0, 'h0F, 0, 0);
        issue(12, 'h10, 'h11, 1, 1);
        issue(12, 'h0C, 'h0A, 1, 0);
        issue(10, 'h7F, 'h00, 1, 0);

        // Reset in the middle of a multiply: no completion, outputs cleared at once.
        bus.i_start = 1'b1;
        bus.i_op    = 4'd12;
        bus.i_a     = 8'h03;
        bus.i_b     = 8'h05;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_mid_mul",
              int'({bus.o_c, bus.o_cf, bus.o_zf, bus.o_nf, bus.o_vf, bus.o_busy, bus.o_done}), 0);
        m_cf = 0; m_zf = 0; m_nf = 0; m_vf = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(12, 'h03, 'h05, 1, 0);

        for (int i = 0; i < 300; i++) begin
            issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
                  $urandom_range(0, 3) == 0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
